// File: rtl/sm4_pkg.sv
// Shared definitions for the SM4 stream feeder: widths, lane ordering and
// the feeder control states.
package sm4_pkg;

    localparam int WORD_W          = 32;
    localparam int BLOCK_W         = 128;
    localparam int WORDS_PER_BLOCK = BLOCK_W / WORD_W;
    localparam int HOLD_W          = BLOCK_W - WORD_W;

    // The first word of a group lands in the most significant lane.
    localparam bit FIRST_WORD_MSB  = 1'b1;

    typedef enum logic [1:0] {
        S_KEY     = 2'd0,
        S_KEY_EXP = 2'd1,
        S_RUN     = 2'd2
    } state_t;

endpackage

// File: rtl/sm4_word_packer.sv
// Collects 32-bit words into a 128-bit value; the fourth word is taken
// straight from the input so the full block is ready on the 4th accept.
module sm4_word_packer
    import sm4_pkg::*;
#(
    parameter bit MSW_FIRST = FIRST_WORD_MSB
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               accept,
    input  logic [WORD_W-1:0]  word,
    output logic [1:0]         word_cnt,
    output logic               last_word,
    output logic [BLOCK_W-1:0] packed_block
);

    logic [1:0]         word_cnt_reg;
    logic [HOLD_W-1:0]  hold_reg;
    logic [BLOCK_W-1:0] chain;

    always_ff @(posedge clk) begin
        if (reset) begin
            word_cnt_reg <= '0;
            hold_reg     <= '0;
        end else if (accept) begin
            word_cnt_reg <= word_cnt_reg + 2'd1;
            hold_reg     <= {hold_reg[HOLD_W-WORD_W-1:0], word};
        end
    end

    // chain holds the oldest word in its top lane and the live word in lane 0.
    assign chain = {hold_reg, word};

    genvar gi;
    generate
        for (gi = 0; gi < WORDS_PER_BLOCK; gi++) begin : g_lane
            localparam int SRC = MSW_FIRST ? gi : (WORDS_PER_BLOCK - 1 - gi);
            assign packed_block[gi*WORD_W +: WORD_W] = chain[SRC*WORD_W +: WORD_W];
        end
    endgenerate

    assign word_cnt  = word_cnt_reg;
    assign last_word = (word_cnt_reg == 2'd3);

endmodule

// File: rtl/sm4_stream_feeder.sv
// Front end of the SM4 core: packs the word stream into key and data blocks,
// sequences key expansion and limits the number of blocks in flight.
module sm4_stream_feeder
    import sm4_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_encdec_in,
    input  logic               s_valid_in,
    input  logic               s_is_key_in,
    input  logic [WORD_W-1:0]  s_data_in,
    output logic               s_ready_out,
    output logic               sm4_enable_out,
    output logic               enable_key_exp_out,
    output logic               user_key_valid_out,
    output logic [BLOCK_W-1:0] user_key_out,
    input  logic               key_exp_ready_in,
    output logic               valid_out,
    output logic               encdec_enable_out,
    output logic [BLOCK_W-1:0] data_out,
    input  logic               ready_in,
    output logic [CNT_W-1:0]   outstanding_out,
    output logic               err_out
);

    state_t state_reg, state_next;

    logic [1:0]         word_cnt;
    logic               last_word;
    logic [BLOCK_W-1:0] packed_block;

    logic               word_accept;
    logic               key_done;
    logic               blk_done;
    logic               kexp_done;
    logic               drained;
    logic               credit_full;
    logic [CNT_W:0]     in_flight;

    logic               sm4_enable_reg;
    logic               enable_key_exp_reg;
    logic               user_key_valid_reg;
    logic [BLOCK_W-1:0] user_key_reg;
    logic               valid_reg;
    logic               encdec_reg;
    logic [BLOCK_W-1:0] data_reg;
    logic [CNT_W-1:0]   outstanding_reg;
    logic               err_reg;

    sm4_word_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .accept       (word_accept),
        .word         (s_data_in),
        .word_cnt     (word_cnt),
        .last_word    (last_word),
        .packed_block (packed_block)
    );

    // A block strobed this cycle still occupies a credit until the counter sees it.
    assign in_flight   = {1'b0, outstanding_reg} + {{CNT_W{1'b0}}, valid_reg};
    assign credit_full = (in_flight >= (CNT_W+1)'(MAX_OUTSTANDING));
    assign drained     = (word_cnt == 2'd0) && (outstanding_reg == '0) && !valid_reg && !ready_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_KEY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_KEY:     if (key_done) state_next = S_KEY_EXP;
            S_KEY_EXP: if (kexp_done) state_next = S_RUN;
            S_RUN:     if (word_accept && s_is_key_in) state_next = S_KEY;
            default:   state_next = S_KEY;
        endcase
    end

    always_comb begin
        s_ready_out = 1'b0;
        case (state_reg)
            S_KEY:     s_ready_out = s_valid_in && s_is_key_in;
            S_KEY_EXP: s_ready_out = 1'b0;
            S_RUN:     s_ready_out = s_is_key_in ? drained : !(last_word && credit_full);
            default:   s_ready_out = 1'b0;
        endcase
    end

    assign word_accept = s_valid_in && s_ready_out;
    assign key_done    = word_accept && last_word && (state_reg == S_KEY);
    assign blk_done    = word_accept && last_word && (state_reg == S_RUN);
    // The strobe cycle itself never ends expansion, even if the core is already ready.
    assign kexp_done   = (state_reg == S_KEY_EXP) && !user_key_valid_reg && key_exp_ready_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            sm4_enable_reg     <= 1'b0;
            enable_key_exp_reg <= 1'b0;
            user_key_valid_reg <= 1'b0;
            user_key_reg       <= '0;
            valid_reg          <= 1'b0;
            encdec_reg         <= 1'b0;
            data_reg           <= '0;
            outstanding_reg    <= '0;
            err_reg            <= 1'b0;
        end else begin
            user_key_valid_reg <= key_done;
            valid_reg          <= blk_done;

            if (key_done) begin
                user_key_reg       <= packed_block;
                enable_key_exp_reg <= 1'b1;
                sm4_enable_reg     <= 1'b1;
            end else if (kexp_done) begin
                enable_key_exp_reg <= 1'b0;
            end

            if (blk_done) begin
                data_reg   <= packed_block;
                encdec_reg <= cfg_encdec_in;
            end

            if (valid_reg && !ready_in) begin
                outstanding_reg <= outstanding_reg + CNT_W'(1);
            end else if (!valid_reg && ready_in) begin
                if (outstanding_reg != '0) begin
                    outstanding_reg <= outstanding_reg - CNT_W'(1);
                end else begin
                    err_reg <= 1'b1;
                end
            end
        end
    end

    assign sm4_enable_out     = sm4_enable_reg;
    assign enable_key_exp_out = enable_key_exp_reg;
    assign user_key_valid_out = user_key_valid_reg;
    assign user_key_out       = user_key_reg;
    assign valid_out          = valid_reg;
    assign encdec_enable_out  = encdec_reg;
    assign data_out           = data_reg;
    assign outstanding_out    = outstanding_reg;
    assign err_out            = err_reg;

endmodule
